// File: rtl/core_pkg.sv
// core_pkg
// Shared types and constants for the core_s front end.
//   ifu_state_e      : fetch FSM states (request, wait for response, hold for decode)
//   RESET_PC_DEFAULT : address of the first instruction fetched after reset
//   INSTR_W          : instruction word width
package core_pkg;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int          INSTR_W          = 32;

endpackage

// File: rtl/ifu.sv
// ifu
// Instruction fetch unit for core_s. Keeps the next fetch PC, issues one
// instruction-bus read at a time and presents the returned word with its PC
// to decode. A redirect from EX (taken branch / jal / jalr) replaces the PC
// and flushes any wrong-path fetch, whether still on the bus or already
// presented to decode.
//
// Ports
//   clk, rst_b                   : core clock, asynchronous active-low reset
//   ex_redirect_valid/_pc        : redirect request and target (low 2 bits ignored)
//   ibus_req_valid/_ready/_addr  : fetch request handshake, word-aligned address
//   ibus_rsp_valid/_data         : in-order read response, one per accepted request
//   if_valid/_ready/_pc/_instr   : instruction handshake towards decode
module ifu
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               ex_redirect_valid,
    input  logic [XLEN-1:0]    ex_redirect_pc,
    output logic               ibus_req_valid,
    input  logic               ibus_req_ready,
    output logic [XLEN-1:0]    ibus_req_addr,
    input  logic               ibus_rsp_valid,
    input  logic [INSTR_W-1:0] ibus_rsp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    ifu_state_e         r_state;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_req_pc;
    logic               r_kill;
    logic               r_if_valid;
    logic [XLEN-1:0]    r_if_pc;
    logic [INSTR_W-1:0] r_if_instr;

    logic               w_req_fire;
    logic [XLEN-1:0]    w_redirect_pc;

    // The request is a pure function of state, so it never depends
    // combinationally on if_ready or ibus_rsp_valid. Gating with rst_b keeps
    // the bus quiet while reset is held even though the state is already REQ.
    assign ibus_req_valid = rst_b && (r_state == IFU_REQ);
    assign ibus_req_addr  = r_pc;
    assign w_req_fire     = ibus_req_valid && ibus_req_ready;

    // Redirect targets are forced to a word boundary; misalignment is not
    // trapped here.
    assign w_redirect_pc  = ex_redirect_pc & ~XLEN'(3);

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_instr = r_if_instr;

    // Fetch FSM. A redirect overrides the normal transition in every state.
    // r_kill marks the single outstanding request as wrong-path so that its
    // response is swallowed instead of being presented to decode.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= IFU_REQ;
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_kill     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else if (ex_redirect_valid) begin
            r_pc <= w_redirect_pc;
            case (r_state)
                IFU_REQ: begin
                    if (w_req_fire) begin
                        r_state <= IFU_WAIT;
                        r_kill  <= 1'b1;
                    end
                end
                IFU_WAIT: begin
                    if (ibus_rsp_valid) begin
                        r_state <= IFU_REQ;
                        r_kill  <= 1'b0;
                    end else begin
                        r_kill  <= 1'b1;
                    end
                end
                IFU_HOLD: begin
                    // Decode flushes its own copy, so the handshake is dropped
                    // even when if_ready is high this cycle.
                    r_state    <= IFU_REQ;
                    r_if_valid <= 1'b0;
                end
                default: begin
                    r_state <= IFU_REQ;
                    r_kill  <= 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                IFU_REQ: begin
                    if (w_req_fire) begin
                        r_state  <= IFU_WAIT;
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + XLEN'(4);
                    end
                end
                IFU_WAIT: begin
                    if (ibus_rsp_valid) begin
                        if (r_kill) begin
                            r_state <= IFU_REQ;
                            r_kill  <= 1'b0;
                        end else begin
                            r_state    <= IFU_HOLD;
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_req_pc;
                            r_if_instr <= ibus_rsp_data;
                        end
                    end
                end
                IFU_HOLD: begin
                    if (if_ready) begin
                        r_state    <= IFU_REQ;
                        r_if_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IFU_REQ;
                    r_kill  <= 1'b0;
                end
            endcase
        end
    end

    // Only one request is ever outstanding, so a response outside WAIT is a
    // bus protocol violation. The FSM ignores it; this flags it in simulation.
    rspOnlyInWait: assert property (@(posedge clk) disable iff (!rst_b)
        ibus_rsp_valid |-> (r_state == IFU_WAIT));

endmodule

// File: tb/tb_ifu.sv
// tb_ifu
// Scoreboard bench for ifu. Stimulus pushes the expected bus requests and
// the expected decode deliveries into queues; independent monitors pop and
// compare whenever the DUT accepts a request or completes a decode handshake.
// A small bus model answers each accepted request after a programmable delay.
module tb_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_b;
    logic        ex_redirect_valid;
    logic [31:0] ex_redirect_pc;
    logic        ibus_req_valid;
    logic        ibus_req_ready;
    logic [31:0] ibus_req_addr;
    logic        ibus_rsp_valid;
    logic [31:0] ibus_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int vecCount    = 0;
    int missCount   = 0;
    int acceptCount = 0;
    int rspDelay    = 1;

    logic [31:0] expReq[$];
    logic [31:0] expPc[$];

    ifu #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .rst_b             (rst_b),
        .ex_redirect_valid (ex_redirect_valid),
        .ex_redirect_pc    (ex_redirect_pc),
        .ibus_req_valid    (ibus_req_valid),
        .ibus_req_ready    (ibus_req_ready),
        .ibus_req_addr     (ibus_req_addr),
        .ibus_rsp_valid    (ibus_rsp_valid),
        .ibus_rsp_data     (ibus_rsp_data),
        .if_valid          (if_valid),
        .if_ready          (if_ready),
        .if_pc             (if_pc),
        .if_instr          (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents the bus model returns for a given fetch address.
    function automatic logic [31:0] instrOf(input logic [31:0] addr);
        return {addr[7:0], addr[31:8]} ^ 32'h0F0F_5A5A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        vecCount++;
        missCount++;
        $display("[TB] FAIL %s", name);
    endtask

    // Advance n cycles; inputs are then changed 1 time unit after the edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitAccepts(input int target, input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (acceptCount >= target) break;
            applyStimulus(1);
        end
        if (acceptCount < target) failNow({name, " request accept timeout"});
    endtask

    task automatic waitIfValid(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (if_valid === 1'b1) break;
            applyStimulus(1);
        end
        if (if_valid !== 1'b1) failNow({name, " if_valid timeout"});
    endtask

    task automatic waitDrain(input string name);
        int i;
        for (i = 0; i < 60; i++) begin
            if (expPc.size() == 0) break;
            applyStimulus(1);
        end
        if (expPc.size() != 0) failNow({name, " delivery timeout"});
    endtask

    // Bus model: sample the handshake mid-cycle, respond after the edge.
    initial begin
        logic        accNow;
        logic [31:0] addrNow;
        logic        pending;
        logic [31:0] pAddr;
        int          cnt;
        pending = 1'b0;
        pAddr   = '0;
        cnt     = 0;
        ibus_rsp_valid = 1'b0;
        ibus_rsp_data  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            accNow  = rst_b && ibus_req_valid && ibus_req_ready;
            addrNow = ibus_req_addr;
            @(posedge clk);
            #1;
            ibus_rsp_valid = 1'b0;
            ibus_rsp_data  = 32'hDEAD_BEEF;
            if (accNow) begin
                pending = 1'b1;
                cnt     = rspDelay;
                pAddr   = addrNow;
            end
            if (pending) begin
                if (cnt <= 1) begin
                    ibus_rsp_valid = 1'b1;
                    ibus_rsp_data  = instrOf(pAddr);
                    pending        = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Request monitor: every accepted request must be the next expected address.
    always @(negedge clk) begin
        if (rst_b && ibus_req_valid && ibus_req_ready) begin
            acceptCount++;
            if (expReq.size() == 0) begin
                failNow($sformatf("unexpected request addr %h", ibus_req_addr));
            end else begin
                checkOutput("request addr", ibus_req_addr, expReq.pop_front());
            end
        end
    end

    // Delivery monitor: a completed handshake not cancelled by a redirect
    // must carry the next expected PC and its instruction word.
    always @(negedge clk) begin
        if (rst_b && if_valid && if_ready && !ex_redirect_valid) begin
            if (expPc.size() == 0) begin
                failNow($sformatf("unexpected delivery pc %h", if_pc));
            end else begin
                logic [31:0] p;
                p = expPc.pop_front();
                checkOutput("if_pc", if_pc, p);
                checkOutput("if_instr", if_instr, instrOf(p));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int base;
        rst_b             = 1'b0;
        ex_redirect_valid = 1'b0;
        ex_redirect_pc    = '0;
        ibus_req_ready    = 1'b1;
        if_ready          = 1'b1;
        rspDelay          = 1;

        // Reset values.
        applyStimulus(3);
        checkOutput("reset req_valid", {31'd0, ibus_req_valid}, 32'd0);
        checkOutput("reset if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("reset if_pc", if_pc, 32'd0);
        checkOutput("reset if_instr", if_instr, 32'd0);

        // Free-running bus: three sequential fetches.
        expReq.push_back(32'h8000_0000);
        expReq.push_back(32'h8000_0004);
        expReq.push_back(32'h8000_0008);
        expPc.push_back(32'h8000_0000);
        expPc.push_back(32'h8000_0004);
        expPc.push_back(32'h8000_0008);
        base  = acceptCount;
        rst_b = 1'b1;
        #4;
        checkOutput("first req_valid", {31'd0, ibus_req_valid}, 32'd1);
        checkOutput("first req addr", ibus_req_addr, RST_PC);
        applyStimulus(1);
        checkOutput("if_valid cycle2", {31'd0, if_valid}, 32'd0);
        applyStimulus(1);
        checkOutput("if_valid cycle3", {31'd0, if_valid}, 32'd1);
        waitAccepts(base + 3, "seq");
        ibus_req_ready = 1'b0;
        waitDrain("seq");

        // Decode stalls for five cycles in HOLD.
        if_ready = 1'b0;
        expReq.push_back(32'h8000_000C);
        expPc.push_back(32'h8000_000C);
        base = acceptCount;
        ibus_req_ready = 1'b1;
        waitAccepts(base + 1, "hold");
        ibus_req_ready = 1'b0;
        waitIfValid("hold");
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold if_valid", {31'd0, if_valid}, 32'd1);
            checkOutput("hold if_pc", if_pc, 32'h8000_000C);
            checkOutput("hold if_instr", if_instr, instrOf(32'h8000_000C));
            checkOutput("hold req_valid", {31'd0, ibus_req_valid}, 32'd0);
            applyStimulus(1);
        end
        if_ready = 1'b1;
        waitDrain("hold");

        // Redirect in the same cycle the request at 0x80000010 is accepted.
        checkOutput("parked addr", ibus_req_addr, 32'h8000_0010);
        expReq.push_back(32'h8000_0010);
        expReq.push_back(32'h8000_0200);
        expPc.push_back(32'h8000_0200);
        base = acceptCount;
        ibus_req_ready    = 1'b1;
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 32'h8000_0200;
        applyStimulus(1);
        ex_redirect_valid = 1'b0;
        waitAccepts(base + 2, "accept redirect");
        ibus_req_ready = 1'b0;
        waitDrain("accept redirect");

        // Redirect (misaligned target) while waiting, response two cycles later.
        rspDelay = 2;
        expReq.push_back(32'h8000_0204);
        expReq.push_back(32'h8000_0100);
        expPc.push_back(32'h8000_0100);
        base = acceptCount;
        ibus_req_ready = 1'b1;
        waitAccepts(base + 1, "wait redirect");
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 32'h8000_0103;
        applyStimulus(1);
        ex_redirect_valid = 1'b0;
        applyStimulus(1);
        checkOutput("stale if_valid", {31'd0, if_valid}, 32'd0);
        waitAccepts(base + 2, "wait redirect");
        ibus_req_ready = 1'b0;
        waitDrain("wait redirect");

        // Redirect in HOLD while decode is ready.
        rspDelay = 1;
        if_ready = 1'b0;
        expReq.push_back(32'h8000_0104);
        base = acceptCount;
        ibus_req_ready = 1'b1;
        waitAccepts(base + 1, "hold redirect");
        ibus_req_ready = 1'b0;
        waitIfValid("hold redirect");
        if_ready          = 1'b1;
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 32'h8000_0300;
        applyStimulus(1);
        ex_redirect_valid = 1'b0;
        checkOutput("hold redirect if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("hold redirect req_valid", {31'd0, ibus_req_valid}, 32'd1);
        checkOutput("hold redirect addr", ibus_req_addr, 32'h8000_0300);
        expReq.push_back(32'h8000_0300);
        expPc.push_back(32'h8000_0300);
        base = acceptCount;
        ibus_req_ready = 1'b1;
        waitAccepts(base + 1, "hold redirect");
        ibus_req_ready = 1'b0;
        waitDrain("hold redirect");

        // Unaccepted request for four cycles, then a redirect moves the address.
        for (int i = 0; i < 4; i++) begin
            checkOutput("stalled req_valid", {31'd0, ibus_req_valid}, 32'd1);
            checkOutput("stalled addr", ibus_req_addr, 32'h8000_0304);
            applyStimulus(1);
        end
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 32'h8000_0400;
        applyStimulus(1);
        ex_redirect_valid = 1'b0;
        checkOutput("switched addr", ibus_req_addr, 32'h8000_0400);
        expReq.push_back(32'h8000_0400);
        expPc.push_back(32'h8000_0400);
        base = acceptCount;
        ibus_req_ready = 1'b1;
        waitAccepts(base + 1, "stall redirect");
        ibus_req_ready = 1'b0;
        waitDrain("stall redirect");

        // Back-to-back redirects (last wins) to the top word; PC then wraps.
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 32'h1234_5678;
        applyStimulus(1);
        ex_redirect_pc    = 32'hFFFF_FFFE;
        applyStimulus(1);
        ex_redirect_valid = 1'b0;
        checkOutput("top addr", ibus_req_addr, 32'hFFFF_FFFC);
        expReq.push_back(32'hFFFF_FFFC);
        expPc.push_back(32'hFFFF_FFFC);
        base = acceptCount;
        ibus_req_ready = 1'b1;
        waitAccepts(base + 1, "wrap");
        ibus_req_ready = 1'b0;
        waitDrain("wrap");
        checkOutput("wrapped addr", ibus_req_addr, 32'h0000_0000);

        applyStimulus(3);
        checkOutput("leftover requests", expReq.size(), 32'd0);
        checkOutput("leftover deliveries", expPc.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit for core_s.
- Holds the PC, issues one instruction-bus read at a time, and presents the fetched instruction/PC to decode.
- Consumes the redirect produced by the branch/jump path (branch unit taken result combined with jal/jalr in EX).
- Redirect flushes any wrong-path fetch, whether in flight or buffered.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h8000_0000, PC loaded on reset

Ports:
clk  in  1  core clock
rst_b  in  1  asynchronous active-low reset
ex_redirect_valid  in  1  EX resolved branch taken / jump; redirect fetch
ex_redirect_pc  in  XLEN  redirect target
ibus_req_valid  out  1  fetch request valid
ibus_req_ready  in  1  bus accepts request
ibus_req_addr  out  XLEN  fetch address (word aligned)
ibus_rsp_valid  in  1  read data valid (one per accepted request, in order)
ibus_rsp_data  in  32  instruction word
if_valid  out  1  instruction valid to decode
if_ready  in  1  decode accepts instruction
if_pc  out  XLEN  PC of presented instruction
if_instr  out  32  presented instruction

Behaviour:
- Interface: single clock clk; reset rst_b is asynchronous, active-low. All state is reset asynchronously.
- Reset values:
  - state=REQ, pc=RESET_PC, kill=0
  - if_valid=0, if_pc=0, if_instr=0
  - ibus_req_valid=0 while rst_b low
  - First request (addr RESET_PC) asserts in the first cycle after release.
- State register pc: the next fetch address. req_pc latches the address of the accepted request. pc <= pc+4 on request accept, wrapping at 2^XLEN.
- FSM states and transitions:
  - REQ: ibus_req_valid=1, ibus_req_addr=pc. On valid&ready -> WAIT, req_pc<=pc.
  - WAIT: on ibus_rsp_valid: if kill=0 -> HOLD, load if_instr<=rsp_data, if_pc<=req_pc, if_valid<=1. If kill=1 -> drop data, clear kill, -> REQ.
  - HOLD: if_valid=1; outputs stable until if_ready. On if_valid&if_ready -> REQ, if_valid<=0.
- Latency: request accept to if_valid = rsp latency + 1 cycle (response registered). Best-case throughput is 1 instruction per 3 cycles (multicycle core, no overlap).
- Redirect (ex_redirect_valid=1) has highest priority in every state:
  - pc <= {ex_redirect_pc[XLEN-1:2],2'b00}; low bits are ignored, no misalign trap here.
  - REQ without accept: ibus_req_addr changes next cycle. The bus must tolerate an address change on an unaccepted request; this is only allowed on redirect.
  - REQ with accept in the same cycle: -> WAIT with kill<=1.
  - WAIT, no rsp: kill<=1, stay WAIT.
  - WAIT, rsp same cycle: drop rsp, -> REQ.
  - HOLD: if_valid<=0 (even if if_ready=1 that cycle; decode flushes its own copy), -> REQ.
  - Redirect asserted on consecutive cycles: the last target wins.
- At most one outstanding request. A response while not in WAIT is a bus protocol error; it is ignored and an assertion fires.
- ibus_req_valid is never combinationally dependent on if_ready or ibus_rsp_valid.

Decomposition:
- Shared package core_pkg:
  - fetch FSM enum (IFU_REQ, IFU_WAIT, IFU_HOLD)
  - default RESET_PC constant
  - INSTR_W=32
- Single module; no sub-module required.
- Output register/handshake stays inline.

Test Plan:
- Reset then free-running bus (ready=1, rsp 1 cycle later) -> requests at 0x80000000, 0x80000004, 0x80000008. if_pc/if_instr match in order; if_valid first high 3 cycles after reset release.
- if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_instr held constant; no new ibus request until the handshake.
- Redirect to 0x80000103 while WAIT, rsp 2 cycles later -> stale rsp dropped, if_valid never asserts for it; next request addr 0x80000100.
- Redirect in the same cycle as request accept at 0x80000010 -> that response is discarded; next fetch at the redirect target.
- Redirect in HOLD with if_ready=1 -> if_valid=0 next cycle, new request at target.
- ibus_req_ready held low 4 cycles, then redirect -> addr switches to target, accepted once ready rises; only the target instruction is delivered.
